// File: rtl/clock_pkg.sv
// Shared constants, BCD digit type and hour-sequencing helpers for the clock,
// alarm and display stages.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_ZERO       = 4'd0;
  localparam bcd_t       LSD_MAX        = 4'd9;
  localparam bcd_t       SEC_MAX_MSD    = 4'd5;
  localparam bcd_t       MIN_MAX_MSD    = 4'd5;
  localparam logic [7:0] HOUR_MAX       = 8'h12;
  localparam logic [7:0] HOUR_PM_TOGGLE = 8'h11;
  localparam logic [7:0] HOUR_WRAP_TO   = 8'h01;

  function automatic logic hour_legal(input logic [7:0] h);
    logic ok;
    if (h[7:4] == 4'd0) begin
      ok = (h[3:0] >= 4'd1) && (h[3:0] <= 4'd9);
    end else if (h[7:4] == 4'd1) begin
      ok = (h[3:0] <= 4'd2);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // 12 -> 01 -> ... -> 11 -> 12; anything illegal recovers to 01
  function automatic logic [7:0] hour_next(input logic [7:0] h);
    logic [7:0] n;
    if (!hour_legal(h) || (h == HOUR_MAX)) begin
      n = HOUR_WRAP_TO;
    end else if (h[3:0] == LSD_MAX) begin
      n = {h[7:4] + 4'd1, BCD_ZERO};
    end else begin
      n = {h[7:4], h[3:0] + 4'd1};
    end
    return n;
  endfunction

endpackage

// File: rtl/clock_time_counter_bcd_digit.sv
// Single BCD digit counter with terminal-value wrap, synchronous clear and
// carry-out; an out-of-range value wraps to zero on its next increment.
module bcd_digit
  import clock_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  bcd_t reset_val,
  input  logic inc,
  input  logic clr,
  input  bcd_t max_val,
  output bcd_t q,
  output logic carry
);

  bcd_t q_r;
  logic at_max_s;

  assign at_max_s = (q_r >= max_val);
  assign carry    = inc & ~clr & at_max_s;
  assign q        = q_r;

  // digit register: clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= reset_val;
    end else if (clr) begin
      q_r <= BCD_ZERO;
    end else if (inc) begin
      q_r <= at_max_s ? BCD_ZERO : (q_r + 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// 12-hour BCD HH:MM:SS time-of-day counter with AM/PM flag, minute tick and
// level-driven fast time-set for hours and minutes.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_HOURS = 8'h12,
  parameter logic       RESET_PM    = 1'b0
) (
  input  logic       clk_1hz,
  input  logic       reset,
  input  logic       en,
  input  logic       set_hours,
  input  logic       set_minutes,
  output logic       clock_pm,
  output logic [3:0] clock_hours_msd,
  output logic [3:0] clock_hours_lsd,
  output logic [3:0] clock_minutes_msd,
  output logic [3:0] clock_minutes_lsd,
  output logic [3:0] clock_seconds_msd,
  output logic [3:0] clock_seconds_lsd,
  output logic       minute_tick
);

  logic       run_s;
  logic       set_s;
  logic       sec_lsd_inc_s;
  logic       min_lsd_inc_s;
  logic       hour_step_s;
  logic       sec_lsd_carry_s;
  logic       sec_msd_carry_s;
  logic       min_lsd_carry_s;
  logic       min_msd_carry_s;
  bcd_t       sec_lsd_s;
  bcd_t       sec_msd_s;
  bcd_t       min_lsd_s;
  bcd_t       min_msd_s;
  logic [7:0] hours_r;
  logic       pm_r;
  logic       minute_tick_r;

  assign run_s = en & ~set_hours & ~set_minutes;
  assign set_s = en & (set_hours | set_minutes);

  // increment sources: natural carry chain in run mode, set inputs otherwise
  always_comb begin
    sec_lsd_inc_s = 1'b0;
    min_lsd_inc_s = 1'b0;
    hour_step_s   = 1'b0;
    if (run_s) begin
      sec_lsd_inc_s = 1'b1;
      min_lsd_inc_s = sec_msd_carry_s;
      hour_step_s   = min_msd_carry_s;
    end else if (en) begin
      min_lsd_inc_s = set_minutes;
      hour_step_s   = set_hours;
    end else begin
      sec_lsd_inc_s = 1'b0;
      min_lsd_inc_s = 1'b0;
      hour_step_s   = 1'b0;
    end
  end

  bcd_digit u_sec_lsd (
    .clk(clk_1hz), .reset(reset), .reset_val(BCD_ZERO), .inc(sec_lsd_inc_s),
    .clr(set_s), .max_val(LSD_MAX), .q(sec_lsd_s), .carry(sec_lsd_carry_s)
  );

  bcd_digit u_sec_msd (
    .clk(clk_1hz), .reset(reset), .reset_val(BCD_ZERO), .inc(sec_lsd_carry_s),
    .clr(set_s), .max_val(SEC_MAX_MSD), .q(sec_msd_s), .carry(sec_msd_carry_s)
  );

  // minute digits are never cleared; in set mode the msd carry is simply ignored
  bcd_digit u_min_lsd (
    .clk(clk_1hz), .reset(reset), .reset_val(BCD_ZERO), .inc(min_lsd_inc_s),
    .clr(1'b0), .max_val(LSD_MAX), .q(min_lsd_s), .carry(min_lsd_carry_s)
  );

  bcd_digit u_min_msd (
    .clk(clk_1hz), .reset(reset), .reset_val(BCD_ZERO), .inc(min_lsd_carry_s),
    .clr(1'b0), .max_val(MIN_MAX_MSD), .q(min_msd_s), .carry(min_msd_carry_s)
  );

  // hours and AM/PM flag; pm flips on the 11 -> 12 step in both run and set
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      hours_r <= RESET_HOURS;
      pm_r    <= RESET_PM;
    end else if (hour_step_s) begin
      hours_r <= hour_next(hours_r);
      pm_r    <= (hours_r == HOUR_PM_TOGGLE) ? ~pm_r : pm_r;
    end else begin
      hours_r <= hours_r;
      pm_r    <= pm_r;
    end
  end

  // minute tick marks the MM:00 produced by a natural seconds carry
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      minute_tick_r <= 1'b0;
    end else if (en) begin
      minute_tick_r <= run_s & sec_msd_carry_s;
    end else begin
      minute_tick_r <= minute_tick_r;
    end
  end

  assign clock_pm          = pm_r;
  assign clock_hours_msd   = hours_r[7:4];
  assign clock_hours_lsd   = hours_r[3:0];
  assign clock_minutes_msd = min_msd_s;
  assign clock_minutes_lsd = min_lsd_s;
  assign clock_seconds_msd = sec_msd_s;
  assign clock_seconds_lsd = sec_lsd_s;
  assign minute_tick       = minute_tick_r;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed plus randomized bench for clock_time_counter against a
// time-of-day reference model (hour-of-day index, minute and second integers).
`timescale 1ns/1ps
module tb_clock_time_counter;

  logic       clk_1hz = 1'b0;
  logic       reset;
  logic       en;
  logic       set_hours;
  logic       set_minutes;
  logic       clock_pm;
  logic [3:0] clock_hours_msd;
  logic [3:0] clock_hours_lsd;
  logic [3:0] clock_minutes_msd;
  logic [3:0] clock_minutes_lsd;
  logic [3:0] clock_seconds_msd;
  logic [3:0] clock_seconds_lsd;
  logic       minute_tick;

  int   total = 0;
  int   bad   = 0;
  int   m_hr24;
  int   m_min;
  int   m_sec;
  logic m_tick;

  clock_time_counter #(.RESET_HOURS(8'h12), .RESET_PM(1'b0)) dut (
    .clk_1hz(clk_1hz), .reset(reset), .en(en),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .clock_pm(clock_pm),
    .clock_hours_msd(clock_hours_msd), .clock_hours_lsd(clock_hours_lsd),
    .clock_minutes_msd(clock_minutes_msd), .clock_minutes_lsd(clock_minutes_lsd),
    .clock_seconds_msd(clock_seconds_msd), .clock_seconds_lsd(clock_seconds_lsd),
    .minute_tick(minute_tick)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_hr24 = 0;
    m_min  = 0;
    m_sec  = 0;
    m_tick = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic sh, input logic sm);
    if (e && (sh || sm)) begin
      m_sec  = 0;
      m_tick = 1'b0;
      if (sm) m_min = (m_min + 1) % 60;
      if (sh) m_hr24 = (m_hr24 + 1) % 24;
    end else if (e) begin
      m_tick = 1'b0;
      m_sec  = m_sec + 1;
      if (m_sec == 60) begin
        m_sec  = 0;
        m_tick = 1'b1;
        m_min  = m_min + 1;
        if (m_min == 60) begin
          m_min  = 0;
          m_hr24 = (m_hr24 + 1) % 24;
        end
      end
    end
  endtask

  task automatic expect_time(input string tag, input int h, input int m, input int s,
                             input logic pm, input logic tick);
    chk({tag, "_hmsd"}, {4'd0, clock_hours_msd},   8'(h / 10));
    chk({tag, "_hlsd"}, {4'd0, clock_hours_lsd},   8'(h % 10));
    chk({tag, "_mmsd"}, {4'd0, clock_minutes_msd}, 8'(m / 10));
    chk({tag, "_mlsd"}, {4'd0, clock_minutes_lsd}, 8'(m % 10));
    chk({tag, "_smsd"}, {4'd0, clock_seconds_msd}, 8'(s / 10));
    chk({tag, "_slsd"}, {4'd0, clock_seconds_lsd}, 8'(s % 10));
    chk({tag, "_pm"},   {7'd0, clock_pm},          {7'd0, pm});
    chk({tag, "_tick"}, {7'd0, minute_tick},       {7'd0, tick});
  endtask

  task automatic check_model(input string tag);
    int h12;
    h12 = ((m_hr24 % 12) == 0) ? 12 : (m_hr24 % 12);
    expect_time(tag, h12, m_min, m_sec, (m_hr24 >= 12), m_tick);
  endtask

  task automatic step(input string tag, input logic e, input logic sh, input logic sm);
    @(negedge clk_1hz);
    en          = e;
    set_hours   = sh;
    set_minutes = sm;
    @(posedge clk_1hz);
    model_step(e, sh, sm);
    #1;
    check_model(tag);
  endtask

  task automatic repeat_step(input string tag, input int n, input logic e,
                             input logic sh, input logic sm);
    for (int i = 0; i < n; i++) step(tag, e, sh, sm);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; set_hours = 1'b0; set_minutes = 1'b0;
    model_reset();
    #3;
    check_model("reset");
    expect_time("reset_c", 12, 0, 0, 1'b0, 1'b0);
    @(negedge clk_1hz);
    reset = 1'b0;

    // 1: free run from reset
    repeat_step("run5", 5, 1'b1, 1'b0, 1'b0);
    expect_time("t1", 12, 0, 5, 1'b0, 1'b0);

    // 2: preload 11:59:58 AM then cross noon
    repeat_step("pre_both", 11, 1'b1, 1'b1, 1'b1);
    repeat_step("pre_min", 48, 1'b1, 1'b0, 1'b1);
    repeat_step("pre_run", 58, 1'b1, 1'b0, 1'b0);
    expect_time("t2_pre", 11, 59, 58, 1'b0, 1'b0);
    step("t2a", 1'b1, 1'b0, 1'b0);
    expect_time("t2a_c", 11, 59, 59, 1'b0, 1'b0);
    step("t2b", 1'b1, 1'b0, 1'b0);
    expect_time("t2b_c", 12, 0, 0, 1'b1, 1'b1);

    // 3: 12:59:59 PM -> 01 PM, then 11:59:59 PM -> 12 AM
    repeat_step("run_hr", 3599, 1'b1, 1'b0, 1'b0);
    expect_time("t3_pre", 12, 59, 59, 1'b1, 1'b0);
    step("t3a", 1'b1, 1'b0, 1'b0);
    expect_time("t3a_c", 1, 0, 0, 1'b1, 1'b1);
    repeat_step("t3_sh", 10, 1'b1, 1'b1, 1'b0);
    repeat_step("t3_sm", 59, 1'b1, 1'b0, 1'b1);
    repeat_step("t3_run", 59, 1'b1, 1'b0, 1'b0);
    expect_time("t3_pre2", 11, 59, 59, 1'b1, 1'b0);
    step("t3b", 1'b1, 1'b0, 1'b0);
    expect_time("t3b_c", 12, 0, 0, 1'b0, 1'b1);

    // 4: set_minutes wraps without hour carry
    repeat_step("t4_sh", 3, 1'b1, 1'b1, 1'b0);
    repeat_step("t4_sm", 58, 1'b1, 1'b0, 1'b1);
    repeat_step("t4_run", 7, 1'b1, 1'b0, 1'b0);
    step("t4a", 1'b1, 1'b0, 1'b1);
    expect_time("t4a_c", 3, 59, 0, 1'b0, 1'b0);
    step("t4b", 1'b1, 1'b0, 1'b1);
    expect_time("t4b_c", 3, 0, 0, 1'b0, 1'b0);
    step("t4c", 1'b1, 1'b0, 1'b1);
    expect_time("t4c_c", 3, 1, 0, 1'b0, 1'b0);

    // 5: set_hours across 11 -> 12 toggles pm; both set inputs together
    repeat_step("t5_sh", 7, 1'b1, 1'b1, 1'b0);
    repeat_step("t5_sm", 14, 1'b1, 1'b0, 1'b1);
    expect_time("t5_pre", 10, 15, 0, 1'b0, 1'b0);
    step("t5a", 1'b1, 1'b1, 1'b0);
    expect_time("t5a_c", 11, 15, 0, 1'b0, 1'b0);
    step("t5b", 1'b1, 1'b1, 1'b0);
    expect_time("t5b_c", 12, 15, 0, 1'b1, 1'b0);
    step("t5c", 1'b1, 1'b1, 1'b0);
    expect_time("t5c_c", 1, 15, 0, 1'b1, 1'b0);
    repeat_step("t5_sm2", 46, 1'b1, 1'b0, 1'b1);
    step("t5d", 1'b1, 1'b1, 1'b1);
    expect_time("t5d_c", 2, 2, 0, 1'b1, 1'b0);

    // 6: freeze, then asynchronous reset while setting
    repeat_step("t6_sh", 3, 1'b1, 1'b1, 1'b0);
    repeat_step("t6_sm", 28, 1'b1, 1'b0, 1'b1);
    repeat_step("t6_run", 20, 1'b1, 1'b0, 1'b0);
    repeat_step("t6_hold", 10, 1'b0, 1'b0, 1'b0);
    expect_time("t6_hold_c", 5, 30, 20, 1'b1, 1'b0);
    step("t6_set", 1'b1, 1'b1, 1'b0);
    @(negedge clk_1hz);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    expect_time("t6_rst", 12, 0, 0, 1'b0, 1'b0);
    @(negedge clk_1hz);
    reset = 1'b0; en = 1'b0; set_hours = 1'b0;
    #1;
    expect_time("t6_rst_hold", 12, 0, 0, 1'b0, 1'b0);

    // randomized mix of freeze, run and set ticks
    for (int i = 0; i < 600; i++) begin
      logic e, sh, sm;
      int   r;
      e  = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 15);
      sh = (r == 0) || (r == 2);
      sm = (r == 1) || (r == 2);
      step("rand", e, sh, sm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
